// File: rtl/nf_bus_rr_arb.sv
// Round-robin arbiter sharing one req/req_ack slave port among M_NUM masters.
// A watchdog aborts a transaction the slave never acknowledges.
module nf_bus_rr_arb #(
    parameter int unsigned M_NUM   = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [M_NUM*32-1:0] addr_m,
    input  logic [M_NUM*32-1:0] wd_m,
    input  logic [M_NUM-1:0]    we_m,
    input  logic [M_NUM-1:0]    req_m,
    output logic [31:0]         rd_m,
    output logic [M_NUM-1:0]    req_ack_m,
    output logic [M_NUM-1:0]    err_m,
    output logic [31:0]         addr_s,
    output logic [31:0]         wd_s,
    output logic                we_s,
    output logic                req_s,
    input  logic [31:0]         rd_s,
    input  logic                req_ack_s,
    output logic [2:0]          grant_id,
    output logic                busy
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [M_NUM-1:0] OneHot0 = M_NUM'(1);

    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic [255:0] addr_pad, wd_pad;
    logic [7:0]   we_pad, req_pad;
    logic [3:0]   idx;
    logic [2:0]   winner;
    logic         any_req, live, timeout_hit;

    // Zero-padded to 8 masters so a 3-bit grant index is always in range.
    assign addr_pad = 256'(addr_m);
    assign wd_pad   = 256'(wd_m);
    assign we_pad   = 8'(we_m);
    assign req_pad  = 8'(req_m);

    assign live        = req_pad[grant_q];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));
    assign grant_id    = grant_q;

    // First requester found searching cyclically from last_grant+1.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= int'(M_NUM); i++) begin
            idx = {1'b0, last_q} + 4'(i);
            if (idx >= 4'(M_NUM)) idx = idx - 4'(M_NUM);
            if (!any_req && req_pad[idx[2:0]]) begin
                any_req = 1'b1;
                winner  = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_s    = '0;
        wd_s      = '0;
        we_s      = 1'b0;
        req_s     = 1'b0;
        busy      = 1'b0;
        rd_m      = '0;
        req_ack_m = '0;
        err_m     = '0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy   = 1'b1;
                addr_s = addr_pad[{grant_q, 5'd0} +: 32];
                wd_s   = wd_pad[{grant_q, 5'd0} +: 32];
                we_s   = we_pad[grant_q];
                req_s  = live;
                // Master abort takes precedence; an ack beats a same-cycle timeout.
                if (!live || req_ack_s || timeout_hit) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                    cnt_d   = '0;
                    if (live && req_ack_s) begin
                        req_ack_m = OneHot0 << grant_q;
                        rd_m      = rd_s;
                    end else if (live) begin
                        err_m = OneHot0 << grant_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= 3'(M_NUM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nf_bus_rr_arb.sv
// Bench for nf_bus_rr_arb: directed scenarios plus randomized traffic against a
// transaction-level round-robin model.
module tb_nf_bus_rr_arb;

    localparam int M       = 3;
    localparam int TO_MAIN = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [95:0]   addr_m, wd_m;
    logic [2:0]    we_m, req_m;
    logic [31:0]   rd_s;
    logic          req_ack_s;

    logic [31:0]   rd_m, addr_s, wd_s;
    logic [2:0]    req_ack_m, err_m, grant_id;
    logic          we_s, req_s, busy;

    logic [31:0]   rd_m3, addr_s3, wd_s3;
    logic [2:0]    req_ack_m3, err_m3, grant_id3;
    logic          we_s3, req_s3, busy3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nf_bus_rr_arb #(.M_NUM(M), .TIMEOUT(TO_MAIN)) dut (
        .clk(clk), .resetn(resetn), .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m),
        .req_m(req_m), .rd_m(rd_m), .req_ack_m(req_ack_m), .err_m(err_m),
        .addr_s(addr_s), .wd_s(wd_s), .we_s(we_s), .req_s(req_s), .rd_s(rd_s),
        .req_ack_s(req_ack_s), .grant_id(grant_id), .busy(busy)
    );

    nf_bus_rr_arb #(.M_NUM(M), .TIMEOUT(3)) dut3 (
        .clk(clk), .resetn(resetn), .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m),
        .req_m(req_m), .rd_m(rd_m3), .req_ack_m(req_ack_m3), .err_m(err_m3),
        .addr_s(addr_s3), .wd_s(wd_s3), .we_s(we_s3), .req_s(req_s3), .rd_s(rd_s),
        .req_ack_s(req_ack_s), .grant_id(grant_id3), .busy(busy3)
    );

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; req_m = '0; req_ack_s = 1'b0; we_m = '0;
        addr_m = '0; wd_m = '0; rd_s = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; req_m = 3'b111; req_ack_s = 1'b1; rd_s = $urandom;
        addr_m = {$urandom, $urandom, $urandom}; wd_m = addr_m; we_m = 3'b111;
        #1;
        vectors++;
        if ({req_s, busy, we_s, grant_id} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b exp=000000", {req_s, busy, we_s, grant_id});
        end
        vectors++;
        if ({req_ack_m, err_m} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ack_err got=%b exp=000000", {req_ack_m, err_m});
        end
        vectors++;
        if ({rd_m, addr_s, wd_s} !== 96'b0) begin
            miscompares++;
            $display("FAIL reset_data got=%h exp=0", {rd_m, addr_s, wd_s});
        end
        @(negedge clk);
        req_m = '0; req_ack_s = 1'b0; we_m = '0; resetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req_m = 3'b010; addr_m = '0; addr_m[63:32] = 32'h0000_1000; rd_s = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if ({busy, req_s} !== 2'b00) begin
            miscompares++; $display("FAIL single_idle got=%b exp=00", {busy, req_s});
        end
        @(negedge clk); #1;
        vectors++;
        if ({req_s, addr_s, grant_id, req_ack_m} !== {1'b1, 32'h1000, 3'd1, 3'b000}) begin
            miscompares++;
            $display("FAIL single_busy1 got=%b/%h/%0d/%b exp=1/1000/1/000",
                     req_s, addr_s, grant_id, req_ack_m);
        end
        @(negedge clk);
        req_ack_s = 1'b1;
        #1;
        vectors++;
        if ({req_ack_m, rd_m, err_m} !== {3'b010, 32'hDEAD_BEEF, 3'b000}) begin
            miscompares++;
            $display("FAIL single_ack got=%b/%h/%b exp=010/deadbeef/000", req_ack_m, rd_m, err_m);
        end
        @(negedge clk);
        req_ack_s = 1'b0; req_m = '0;
        #1;
        vectors++;
        if ({busy, req_ack_m, rd_m} !== 36'b0) begin
            miscompares++;
            $display("FAIL single_after got=%b/%b/%h exp=0/000/0", busy, req_ack_m, rd_m);
        end
    endtask

    task automatic test_round_robin();
        int         acks[M];
        int         m;
        logic [2:0] exp_ack;
        for (int k = 0; k < M; k++) acks[k] = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_m = 3'b111; req_ack_s = 1'b1;
                addr_m = {$urandom, $urandom, $urandom};
            end
            #1;
            exp_ack = '0;
            m = (c / 2) % M;
            if (c % 2 == 1) exp_ack[m] = 1'b1;
            vectors++;
            if (req_ack_m !== exp_ack || (c % 2 == 1 && grant_id !== 3'(m))) begin
                miscompares++;
                $display("FAIL rr_order c=%0d got=%b/%0d exp=%b/%0d", c, req_ack_m, grant_id,
                         exp_ack, m);
            end
            for (int k = 0; k < M; k++) if (req_ack_m[k] === 1'b1) acks[k]++;
        end
        for (int k = 0; k < M; k++) begin
            vectors++;
            if (acks[k] != 2) begin
                miscompares++; $display("FAIL rr_count m=%0d got=%0d exp=2", k, acks[k]);
            end
        end
        @(negedge clk);
        req_m = '0; req_ack_s = 1'b0;
    endtask

    task automatic test_timeout();
        logic [2:0] exp_err;
        do_reset();
        @(negedge clk);
        req_m = 3'b100; req_ack_s = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) req_m = 3'b101;
            #1;
            exp_err = (c == 4) ? 3'b100 : 3'b000;
            vectors++;
            if ({req_s, grant_id, req_ack_m, err_m} !== {1'b1, 3'd2, 3'b000, exp_err}) begin
                miscompares++;
                $display("FAIL timeout_busy c=%0d got=%b/%0d/%b/%b exp=1/2/000/%b", c, req_s,
                         grant_id, req_ack_m, err_m, exp_err);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if ({req_s, busy, req_ack_m, err_m} !== 8'b0) begin
            miscompares++;
            $display("FAIL timeout_after got=%b/%b/%b/%b exp=0/0/000/000", req_s, busy,
                     req_ack_m, err_m);
        end
        @(negedge clk);
        req_ack_s = 1'b1;
        #1;
        vectors++;
        if ({busy, grant_id, req_ack_m} !== {1'b1, 3'd0, 3'b001}) begin
            miscompares++;
            $display("FAIL timeout_next got=%b/%0d/%b exp=1/0/001", busy, grant_id, req_ack_m);
        end
        @(negedge clk);
        req_m = '0; req_ack_s = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        @(negedge clk);
        req_m = 3'b001;
        @(negedge clk); #1;
        vectors++;
        if ({req_s, grant_id} !== {1'b1, 3'd0}) begin
            miscompares++; $display("FAIL abort_grant got=%b/%0d exp=1/0", req_s, grant_id);
        end
        @(negedge clk);
        req_m = 3'b000;
        #1;
        vectors++;
        if ({req_s, busy, req_ack_m, err_m} !== {1'b0, 1'b1, 6'b0}) begin
            miscompares++;
            $display("FAIL abort_drop got=%b/%b/%b/%b exp=0/1/000/000", req_s, busy,
                     req_ack_m, err_m);
        end
        @(negedge clk); #1;
        vectors++;
        if ({busy, req_ack_m, err_m} !== 7'b0) begin
            miscompares++;
            $display("FAIL abort_idle got=%b/%b/%b exp=0/000/000", busy, req_ack_m, err_m);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req_m = 3'b010;
        @(negedge clk); #1;
        vectors++;
        if ({busy, grant_id} !== {1'b1, 3'd1}) begin
            miscompares++; $display("FAIL rstmid_pre got=%b/%0d exp=1/1", busy, grant_id);
        end
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if ({req_s, busy, grant_id} !== 5'b0) begin
            miscompares++;
            $display("FAIL rstmid_async got=%b/%b/%0d exp=0/0/0", req_s, busy, grant_id);
        end
        @(negedge clk);
        req_m = 3'b011; resetn = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if ({busy, grant_id} !== {1'b1, 3'd0}) begin
            miscompares++; $display("FAIL rstmid_first got=%b/%0d exp=1/0", busy, grant_id);
        end
        @(negedge clk);
        req_m = '0;
    endtask

    task automatic test_coincide();
        do_reset();
        @(negedge clk);
        req_m = 3'b001; rd_s = 32'hC0FF_EE00;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) req_ack_s = 1'b1;
            #1;
            vectors++;
            if (err_m3 !== 3'b000 || req_ack_m3 !== ((c == 3) ? 3'b001 : 3'b000)) begin
                miscompares++;
                $display("FAIL coincide c=%0d got=ack %b err %b", c, req_ack_m3, err_m3);
            end
        end
        @(negedge clk);
        req_m = '0; req_ack_s = 1'b0;
        #1;
        vectors++;
        if ({busy3, err_m3} !== 4'b0) begin
            miscompares++; $display("FAIL coincide_after got=%b/%b exp=0/000", busy3, err_m3);
        end
    endtask

    // Model: one transaction in flight (mb), its master (mg), the last owner (ml) and
    // the number of BUSY cycles already spent without an ack (mc).
    task automatic test_random();
        bit          mb, found, live, e_ack_b, e_err_b;
        int          mg, ml, mc, c;
        logic [2:0]  e_ack, e_err;
        logic [31:0] e_addr, e_wd, e_rd;
        logic        e_we, e_req, e_busy;
        do_reset();
        mb = 1'b0; mg = 0; ml = M - 1; mc = 0;
        req_m = 3'($urandom);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < M; k++) if ($urandom_range(0, 5) == 0) req_m[k] = ~req_m[k];
            addr_m = {$urandom, $urandom, $urandom};
            wd_m   = {$urandom, $urandom, $urandom};
            we_m   = 3'($urandom);
            rd_s   = $urandom;
            req_ack_s = ($urandom_range(0, 3) == 0);
            #1;
            e_ack = '0; e_err = '0; e_addr = '0; e_wd = '0; e_rd = '0;
            e_we = 1'b0; e_req = 1'b0; e_busy = 1'b0;
            live = 1'b0; e_ack_b = 1'b0; e_err_b = 1'b0;
            if (mb) begin
                live    = req_m[mg];
                e_busy  = 1'b1;
                e_req   = live;
                e_addr  = addr_m[32*mg +: 32];
                e_wd    = wd_m[32*mg +: 32];
                e_we    = we_m[mg];
                e_ack_b = live && req_ack_s;
                e_err_b = live && !req_ack_s && (mc + 1 == TO_MAIN);
                if (e_ack_b) begin e_ack[mg] = 1'b1; e_rd = rd_s; end
                if (e_err_b) e_err[mg] = 1'b1;
            end
            vectors++;
            if ({busy, req_s, we_s, grant_id} !== {e_busy, e_req, e_we, 3'(mg)}) begin
                miscompares++;
                $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc,
                         {busy, req_s, we_s, grant_id}, {e_busy, e_req, e_we, 3'(mg)});
            end
            vectors++;
            if ({addr_s, wd_s} !== {e_addr, e_wd}) begin
                miscompares++;
                $display("FAIL rnd_route cyc=%0d got=%h/%h exp=%h/%h", cyc, addr_s, wd_s,
                         e_addr, e_wd);
            end
            vectors++;
            if ({req_ack_m, err_m, rd_m} !== {e_ack, e_err, e_rd}) begin
                miscompares++;
                $display("FAIL rnd_resp cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, req_ack_m,
                         err_m, rd_m, e_ack, e_err, e_rd);
            end
            @(posedge clk);
            if (!mb) begin
                found = 1'b0;
                for (int off = 1; off <= M; off++) begin
                    c = (ml + off) % M;
                    if (!found && req_m[c]) begin
                        found = 1'b1; mg = c; mb = 1'b1; mc = 0;
                    end
                end
            end else if (!live || e_ack_b || e_err_b) begin
                mb = 1'b0; ml = mg; mc = 0;
            end else begin
                mc++;
            end
        end
        @(negedge clk);
        req_m = '0; req_ack_s = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; req_m = '0; req_ack_s = 1'b0; we_m = '0;
        addr_m = '0; wd_m = '0; rd_s = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_coincide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nf_bus_rr_arb.md
Name: nf_bus_rr_arb

Overview:
- N-master round-robin arbiter sharing one slave port that uses the core's req/req_ack handshake.
- Masters are the CPU fetch and data ports plus optional DMA or debug masters; the slave is the cross-connected memory/peripheral bus.
- Grants exactly one master per transaction and routes its address, write data and write enable to the slave.
- Returns ack and read data to the granted master only, with a watchdog against a slave that never acks.

Parameters:
- M_NUM, 3, number of masters; legal range 2..8.
- TIMEOUT, 255, cycles in BUSY without req_ack_s before abort; 0 disables the watchdog.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset: asynchronous, active-low.
- addr_m  input  M_NUM*32  master addresses; master k occupies bits [32k+31:32k].
- wd_m  input  M_NUM*32  master write data, same packing as addr_m.
- we_m  input  M_NUM  master write enables.
- req_m  input  M_NUM  master requests.
- rd_m  output  32  read data; valid only in the cycle the matching req_ack_m bit is high.
- req_ack_m  output  M_NUM  per-master acknowledge pulse.
- err_m  output  M_NUM  per-master timeout-abort pulse.
- addr_s  output  32  slave address.
- wd_s  output  32  slave write data.
- we_s  output  1  slave write enable.
- req_s  output  1  slave request.
- rd_s  input  32  slave read data.
- req_ack_s  input  1  slave acknowledge.
- grant_id  output  3  index of the current or last granted master.
- busy  output  1  high in the BUSY state.

Behaviour:
- Reset:
  - All outputs go to 0.
  - State is IDLE, grant_id is 0, the watchdog counter is 0.
  - Internal last_grant is M_NUM-1, so master 0 wins the first arbitration.
- State IDLE:
  - Slave outputs are 0 and busy is 0.
  - If any req_m bit is high, the winner is the first set bit searched cyclically from last_grant+1 (mod M_NUM).
  - The winner is registered into grant_id, and the FSM enters BUSY on the next edge.
  - No req_m bit high: stay in IDLE.
- State BUSY:
  - addr_s, wd_s, we_s and req_s are driven combinationally from master grant_id.
  - busy is 1.
  - Minimum latency from req_m rising to req_s high is 1 cycle.
- Completion, when req_ack_s=1 in BUSY:
  - In the same cycle, req_ack_m[grant_id]=1 and rd_m=rd_s; every other req_ack_m bit stays 0.
  - At the next edge: last_grant<=grant_id, state<=IDLE, counter<=0.
  - A master that keeps req high after its ack is re-arbitrated fairly and never wins back-to-back while another master is requesting.
- Round-robin throughput: a transaction costs at least 2 cycles (1 IDLE + 1 BUSY). IDLE-to-BUSY re-arbitration always consumes one cycle.
- Watchdog (TIMEOUT != 0):
  - The counter increments on every BUSY cycle without req_ack_s.
  - When it reaches TIMEOUT, err_m[grant_id] pulses for 1 cycle, req_s drops, state returns to IDLE, and last_grant is updated.
  - No req_ack_m is issued for the aborted transaction.
  - An ack in the same cycle as the timeout wins: it is a normal completion with no err.
- Master abort: if req_m[grant_id] falls while in BUSY without an ack, return to IDLE next edge with no ack and no err. req_s follows req_m combinationally, so it drops in that same cycle.
- Non-granted masters: input changes have no effect on the slave outputs.
- rd_m is 0 whenever no req_ack_m bit is high.
- Reset asserted mid-transaction: outputs go to 0 immediately (asynchronous), the pending transaction is lost, and arbitration restarts at master 0.
- Widths: the counter is 8 bits wide, wide enough for TIMEOUT up to 255. grant_id is zero-extended to 3 bits.

Test Plan:
- Single master: req_m=3'b010, addr_m[63:32]=32'h0000_1000, slave acks on the 2nd BUSY cycle.
  - Required: req_s high from cycle 1, addr_s=32'h1000.
  - Required: req_ack_m=3'b010 and rd_m=rd_s=32'hDEAD_BEEF for 1 cycle.
  - Required: grant_id=1.
- All three masters requesting continuously, slave acks every BUSY cycle.
  - Required: grant order 0,1,2,0,1,2 and each master receives exactly 2 acks in 12 cycles.
- Timeout: TIMEOUT=4, master 2 requests, slave never acks.
  - Required: err_m=3'b100 for 1 cycle after 4 BUSY cycles, req_s=0 the next cycle, no req_ack_m.
  - Required: the next grant goes to master 0 when it is requesting.
- Abort: master 0 is granted and drops req_m[0] in BUSY.
  - Required: req_s=0 in that same cycle, state IDLE the next cycle, no ack, no err.
- Reset mid-BUSY: resetn=0 while master 1 is granted.
  - Required: req_s, busy and grant_id are 0 asynchronously.
  - Required: after release with req_m=3'b011, master 0 is granted first.
- Ack coinciding with timeout: TIMEOUT=3, ack in the 3rd BUSY cycle.
  - Required: req_ack_m pulses and err_m stays 0.
